ex_mc_ctrl: RTL and testbench

Multi-cycle execute sequencer and pipeline stall generator for the five-stage core. It watches the ALU op currently held in the execute stage. It sequences two-cycle MADD/MADDU/MSUB/MSUBU and the handshake with the iterative divider, buffering intermediate and final 64-bit results. It merges its own stall need with the IF/ID/MEM stall requests into the 6-bit `stall` vector consumed by every pipeline register.

---
 rtl/ex_mc_ctrl_pkg.sv | 43 ++++
 rtl/ex_mc_ctrl_stall_enc.sv | 24 ++
 rtl/ex_mc_ctrl.sv | 153 +++++++++++++++
 tb/tb_ex_mc_ctrl.sv | 293 +++++++++++++++++++++++++++++
 4 files changed

// File: rtl/ex_mc_ctrl_pkg.sv
// Shared definitions for the execute-stage multi-cycle sequencer:
// ALU op encodings, stall polarity, FSM state codes and stall patterns.
package ex_mc_ctrl_pkg;

   // ALU op encodings seen on ex_aluop (AluOpBus)
   localparam logic [7:0] EXE_NOP_OP   = 8'b0000_0000;
   localparam logic [7:0] EXE_MADD_OP  = 8'b1010_0110;
   localparam logic [7:0] EXE_MADDU_OP = 8'b1010_1000;
   localparam logic [7:0] EXE_MSUB_OP  = 8'b1010_1010;
   localparam logic [7:0] EXE_MSUBU_OP = 8'b1010_1011;
   localparam logic [7:0] EXE_DIV_OP   = 8'b0001_1010;
   localparam logic [7:0] EXE_DIVU_OP  = 8'b0001_1011;

   // Stall bit polarity: 1 freezes the pipeline register
   localparam logic STOP    = 1'b1;
   localparam logic NO_STOP = 1'b0;

   // Sequencer states
   typedef enum logic [1:0] {
      MC_IDLE     = 2'd0,
      MC_MADD2    = 2'd1,
      MC_DIV_WAIT = 2'd2,
      MC_DIV_DONE = 2'd3
   } mc_state_t;

   // Stall patterns, bit 0 = PC ... bit 5 = WB; the requesting stage and
   // everything upstream of it are frozen
   localparam logic [5:0] STALL_MEM  = 6'b011111;
   localparam logic [5:0] STALL_EX   = 6'b001111;
   localparam logic [5:0] STALL_ID   = 6'b000111;
   localparam logic [5:0] STALL_IF   = 6'b000011;
   localparam logic [5:0] STALL_NONE = 6'b000000;

   function automatic logic is_madd_op(input logic [7:0] op);
      return (op == EXE_MADD_OP) || (op == EXE_MADDU_OP) ||
             (op == EXE_MSUB_OP) || (op == EXE_MSUBU_OP);
   endfunction

   function automatic logic is_div_op(input logic [7:0] op);
      return (op == EXE_DIV_OP) || (op == EXE_DIVU_OP);
   endfunction

endpackage

// File: rtl/ex_mc_ctrl_stall_enc.sv
// Stall priority encoder: the furthest-downstream requesting stage wins;
// kill (flush or reset) forces every pipeline register to advance.
module ex_mc_ctrl_stall_enc
   import ex_mc_ctrl_pkg::*;
(
   input  logic       req_if,
   input  logic       req_id,
   input  logic       req_ex,
   input  logic       req_mem,
   input  logic       kill,
   output logic [5:0] stall
);

   // Priority-encode the stage requests into a freeze pattern
   always_comb begin
      stall = STALL_NONE;
      if (kill)         stall = STALL_NONE;
      else if (req_mem) stall = STALL_MEM;
      else if (req_ex)  stall = STALL_EX;
      else if (req_id)  stall = STALL_ID;
      else if (req_if)  stall = STALL_IF;
   end

endmodule

// File: rtl/ex_mc_ctrl.sv
// Execute-stage multi-cycle sequencer: runs the two-cycle MADD class and the
// divider handshake, buffers their 64-bit results, and produces the
// pipeline stall vector.
// Handshake: div_start_o is a level held from launch until div_ready_i; the
// divider presents div_result_i in the cycle div_ready_i is high, and that
// result is captured only if no flush is present in the same cycle.
module ex_mc_ctrl
   import ex_mc_ctrl_pkg::*;
#(
   parameter int DIV_TIMEOUT = 40
) (
   input  logic        clk,
   input  logic        rst,
   input  logic        stallreq_from_if,
   input  logic        stallreq_from_id,
   input  logic        stallreq_from_mem,
   input  logic        flush,
   input  logic [7:0]  ex_aluop,
   input  logic [63:0] hilo_temp_i,
   input  logic        div_ready_i,
   input  logic [63:0] div_result_i,
   output logic [5:0]  stall,
   output logic        madd_phase_o,
   output logic [63:0] hilo_temp_o,
   output logic        div_start_o,
   output logic        div_signed_o,
   output logic        div_annul_o,
   output logic [63:0] div_result_o,
   output logic        div_result_valid_o,
   output logic        div_timeout_o
);

   localparam int CNT_W = $clog2(DIV_TIMEOUT + 1);

   mc_state_t        state_q, state_d;
   logic [CNT_W-1:0] div_cnt_q;
   logic             div_timeout_q;
   logic [63:0]      hilo_q;
   logic [63:0]      div_res_q;
   logic             div_signed_q;

   logic stallreq_ex;
   logic hilo_load, div_load, div_launch, signed_c;
   logic madd_phase_c, div_start_c, div_annul_c, res_valid_c;

   // Execute-stage stall need, from state and the op held in EX
   always_comb begin
      stallreq_ex = NO_STOP;
      case (state_q)
         MC_IDLE:     stallreq_ex = (is_madd_op(ex_aluop) || is_div_op(ex_aluop)) ? STOP : NO_STOP;
         MC_DIV_WAIT: stallreq_ex = STOP;
         default:     stallreq_ex = NO_STOP;
      endcase
   end

   ex_mc_ctrl_stall_enc u_stall_enc (
      .req_if  (stallreq_from_if),
      .req_id  (stallreq_from_id),
      .req_ex  (stallreq_ex),
      .req_mem (stallreq_from_mem),
      .kill    (flush | rst),
      .stall   (stall)
   );

   // Next state, buffer load enables and state-decoded strobes
   always_comb begin
      state_d      = state_q;
      hilo_load    = 1'b0;
      div_load     = 1'b0;
      div_launch   = 1'b0;
      signed_c     = div_signed_q;
      madd_phase_c = 1'b0;
      div_start_c  = 1'b0;
      div_annul_c  = 1'b0;
      res_valid_c  = 1'b0;
      case (state_q)
         MC_IDLE: begin
            if (is_madd_op(ex_aluop)) begin
               hilo_load = 1'b1;
               state_d   = MC_MADD2;
            end else if (is_div_op(ex_aluop)) begin
               div_start_c = 1'b1;
               div_launch  = 1'b1;
               signed_c    = (ex_aluop == EXE_DIV_OP);
               state_d     = MC_DIV_WAIT;
            end
         end
         MC_MADD2: begin
            madd_phase_c = 1'b1;
            if (stall[3] == NO_STOP) state_d = MC_IDLE;
         end
         MC_DIV_WAIT: begin
            div_start_c = 1'b1;
            if (div_ready_i) begin
               div_load = 1'b1;
               state_d  = MC_DIV_DONE;
            end
         end
         MC_DIV_DONE: begin
            res_valid_c = 1'b1;
            if (stall[3] == NO_STOP) state_d = MC_IDLE;
         end
         default: state_d = MC_IDLE;
      endcase
      // Flush cancels any op in flight; buffers keep their contents
      if (flush) begin
         state_d     = MC_IDLE;
         div_annul_c = (state_q == MC_DIV_WAIT);
         div_start_c = 1'b0;
         res_valid_c = 1'b0;
         hilo_load   = 1'b0;
         div_load    = 1'b0;
         div_launch  = 1'b0;
      end
   end

   // State register
   always_ff @(posedge clk) begin
      if (rst) state_q <= MC_IDLE;
      else     state_q <= state_d;
   end

   // Result buffers, divide sign and the saturating wait counter/timeout
   always_ff @(posedge clk) begin
      if (rst) begin
         hilo_q        <= '0;
         div_res_q     <= '0;
         div_signed_q  <= 1'b0;
         div_cnt_q     <= '0;
         div_timeout_q <= 1'b0;
      end else begin
         if (hilo_load) hilo_q <= hilo_temp_i;
         if (div_load)  div_res_q <= div_result_i;
         if (div_launch) begin
            div_signed_q <= signed_c;
            div_cnt_q    <= '0;
         end else if (state_q == MC_DIV_WAIT) begin
            if (div_cnt_q != {CNT_W{1'b1}}) div_cnt_q <= div_cnt_q + 1'b1;
            if (div_cnt_q >= CNT_W'(DIV_TIMEOUT - 1)) div_timeout_q <= 1'b1;
         end
      end
   end

   assign hilo_temp_o        = hilo_q;
   assign div_result_o       = div_res_q;
   assign div_timeout_o      = div_timeout_q;
   assign madd_phase_o       = ~rst & madd_phase_c;
   assign div_start_o        = ~rst & div_start_c;
   assign div_annul_o        = ~rst & div_annul_c;
   assign div_result_valid_o = ~rst & res_valid_c;
   assign div_signed_o       = ~rst & signed_c;

endmodule

// File: tb/tb_ex_mc_ctrl.sv
// Directed bench for ex_mc_ctrl: inputs change on the falling edge, outputs
// are checked 1 ns later, well away from the rising edge.
module tb_ex_mc_ctrl;
   import ex_mc_ctrl_pkg::*;

   logic        clk;
   logic        rst;
   logic        stallreq_from_if, stallreq_from_id, stallreq_from_mem;
   logic        flush;
   logic [7:0]  ex_aluop;
   logic [63:0] hilo_temp_i;
   logic        div_ready_i;
   logic [63:0] div_result_i;
   logic [5:0]  stall;
   logic        madd_phase_o;
   logic [63:0] hilo_temp_o;
   logic        div_start_o, div_signed_o, div_annul_o;
   logic [63:0] div_result_o;
   logic        div_result_valid_o, div_timeout_o;

   int n_checks = 0;
   int n_fail   = 0;

   ex_mc_ctrl #(.DIV_TIMEOUT(40)) dut (
      .clk(clk), .rst(rst),
      .stallreq_from_if(stallreq_from_if), .stallreq_from_id(stallreq_from_id),
      .stallreq_from_mem(stallreq_from_mem), .flush(flush),
      .ex_aluop(ex_aluop), .hilo_temp_i(hilo_temp_i),
      .div_ready_i(div_ready_i), .div_result_i(div_result_i),
      .stall(stall), .madd_phase_o(madd_phase_o), .hilo_temp_o(hilo_temp_o),
      .div_start_o(div_start_o), .div_signed_o(div_signed_o),
      .div_annul_o(div_annul_o), .div_result_o(div_result_o),
      .div_result_valid_o(div_result_valid_o), .div_timeout_o(div_timeout_o)
   );

   // Clock
   initial begin
      clk = 1'b0;
      forever #5 clk = ~clk;
   end

   task automatic tick();
      @(negedge clk);
   endtask

   task automatic test_reset();
      rst = 1'b1; flush = 1'b0; ex_aluop = EXE_DIV_OP; hilo_temp_i = 64'h1;
      stallreq_from_if = 1'b1; stallreq_from_id = 1'b1; stallreq_from_mem = 1'b1;
      div_ready_i = 1'b0; div_result_i = '0;
      tick(); tick();
      #1;
      n_checks++;
      if (stall !== 6'b000000) begin n_fail++; $display("FAIL reset_stall: got %b want 000000", stall); end
      n_checks++;
      if ({div_start_o, div_signed_o, div_annul_o, madd_phase_o, div_result_valid_o} !== 5'b0) begin
         n_fail++; $display("FAIL reset_strobes: got %b want 00000",
            {div_start_o, div_signed_o, div_annul_o, madd_phase_o, div_result_valid_o});
      end
      n_checks++;
      if ({hilo_temp_o, div_result_o, div_timeout_o} !== 129'b0) begin
         n_fail++; $display("FAIL reset_regs: hilo %h div %h to %b want zeros", hilo_temp_o, div_result_o, div_timeout_o);
      end
      tick();
      rst = 1'b0; ex_aluop = EXE_NOP_OP;
      stallreq_from_if = 1'b0; stallreq_from_id = 1'b0; stallreq_from_mem = 1'b0;
      #1;
      n_checks++;
      if (dut.state_q !== MC_IDLE) begin n_fail++; $display("FAIL reset_state: got %0d want %0d", dut.state_q, MC_IDLE); end
   endtask

   task automatic test_madd();
      tick();
      ex_aluop = EXE_MADD_OP; hilo_temp_i = 64'h0000_0001_0000_0002;
      #1;
      n_checks++;
      if (stall !== 6'b001111) begin n_fail++; $display("FAIL madd_stall1: got %b want 001111", stall); end
      n_checks++;
      if (madd_phase_o !== 1'b0) begin n_fail++; $display("FAIL madd_phase1: got %b want 0", madd_phase_o); end
      tick();
      hilo_temp_i = 64'hdead_beef_dead_beef;
      #1;
      n_checks++;
      if (madd_phase_o !== 1'b1) begin n_fail++; $display("FAIL madd_phase2: got %b want 1", madd_phase_o); end
      n_checks++;
      if (stall !== 6'b000000) begin n_fail++; $display("FAIL madd_stall2: got %b want 000000", stall); end
      n_checks++;
      if (hilo_temp_o !== 64'h0000_0001_0000_0002) begin
         n_fail++; $display("FAIL madd_hilo: got %h want 0000000100000002", hilo_temp_o);
      end
      // back-to-back: next MADD-class op decoded immediately in IDLE
      tick();
      ex_aluop = EXE_MSUBU_OP; hilo_temp_i = 64'hffff_0000_1234_5678;
      #1;
      n_checks++;
      if (dut.state_q !== MC_IDLE) begin n_fail++; $display("FAIL b2b_state: got %0d want %0d", dut.state_q, MC_IDLE); end
      n_checks++;
      if (stall !== 6'b001111) begin n_fail++; $display("FAIL b2b_stall: got %b want 001111", stall); end
      tick();
      #1;
      n_checks++;
      if (hilo_temp_o !== 64'hffff_0000_1234_5678 || madd_phase_o !== 1'b1) begin
         n_fail++; $display("FAIL b2b_hilo: got %h/%b want ffff000012345678/1", hilo_temp_o, madd_phase_o);
      end
      tick();
      ex_aluop = EXE_NOP_OP;
      #1;
      n_checks++;
      if (dut.state_q !== MC_IDLE || madd_phase_o !== 1'b0) begin
         n_fail++; $display("FAIL madd_exit: state %0d phase %b want %0d/0", dut.state_q, madd_phase_o, MC_IDLE);
      end
   endtask

   task automatic test_divu();
      int stalled;
      stalled = 0;
      tick();
      ex_aluop = EXE_DIVU_OP;
      #1;
      n_checks++;
      if (div_start_o !== 1'b1 || div_signed_o !== 1'b0) begin
         n_fail++; $display("FAIL divu_start: start %b signed %b want 1/0", div_start_o, div_signed_o);
      end
      if (stall == 6'b001111) stalled++;
      for (int k = 1; k <= 34; k++) begin
         tick();
         if (k == 34) begin div_ready_i = 1'b1; div_result_i = 64'h3_0000_0005; end
         #1;
         if (stall == 6'b001111 && div_start_o === 1'b1) stalled++;
      end
      n_checks++;
      if (stalled != 35) begin n_fail++; $display("FAIL divu_stall_cycles: got %0d want 35", stalled); end
      tick();
      div_ready_i = 1'b0; div_result_i = '0;
      #1;
      n_checks++;
      if (dut.state_q !== MC_DIV_DONE || stall !== 6'b000000) begin
         n_fail++; $display("FAIL divu_done: state %0d stall %b want %0d/000000", dut.state_q, stall, MC_DIV_DONE);
      end
      n_checks++;
      if (div_result_o !== 64'h3_0000_0005 || div_result_valid_o !== 1'b1) begin
         n_fail++; $display("FAIL divu_result: got %h/%b want 0000000300000005/1", div_result_o, div_result_valid_o);
      end
      n_checks++;
      if (div_start_o !== 1'b0 || div_signed_o !== 1'b0) begin
         n_fail++; $display("FAIL divu_done_strobes: start %b signed %b want 0/0", div_start_o, div_signed_o);
      end
      tick();
      ex_aluop = EXE_NOP_OP;
      #1;
      n_checks++;
      if (dut.state_q !== MC_IDLE || div_result_valid_o !== 1'b0) begin
         n_fail++; $display("FAIL divu_exit: state %0d valid %b want %0d/0", dut.state_q, div_result_valid_o, MC_IDLE);
      end
   endtask

   task automatic test_flush();
      tick();
      ex_aluop = EXE_DIV_OP;
      #1;
      n_checks++;
      if (div_signed_o !== 1'b1) begin n_fail++; $display("FAIL div_signed: got %b want 1", div_signed_o); end
      for (int k = 1; k < 10; k++) tick();
      tick();
      flush = 1'b1;
      #1;
      n_checks++;
      if (div_annul_o !== 1'b1 || stall !== 6'b000000 || div_start_o !== 1'b0) begin
         n_fail++; $display("FAIL flush_cycle: annul %b stall %b start %b want 1/000000/0", div_annul_o, stall, div_start_o);
      end
      tick();
      flush = 1'b0; ex_aluop = EXE_NOP_OP; div_ready_i = 1'b1; div_result_i = 64'hbad0_bad0_bad0_bad0;
      #1;
      n_checks++;
      if (dut.state_q !== MC_IDLE || div_annul_o !== 1'b0 || div_start_o !== 1'b0) begin
         n_fail++; $display("FAIL flush_after: state %0d annul %b start %b want %0d/0/0", dut.state_q, div_annul_o, div_start_o, MC_IDLE);
      end
      tick();
      div_ready_i = 1'b0; div_result_i = '0;
      #1;
      n_checks++;
      if (dut.state_q !== MC_IDLE || div_result_valid_o !== 1'b0 || div_result_o !== 64'h3_0000_0005) begin
         n_fail++; $display("FAIL flush_drop: state %0d valid %b res %h want %0d/0/0000000300000005",
            dut.state_q, div_result_valid_o, div_result_o, MC_IDLE);
      end
   endtask

   task automatic test_stall_prio();
      tick();
      stallreq_from_id = 1'b1; stallreq_from_mem = 1'b1;
      #1;
      n_checks++;
      if (stall !== 6'b011111) begin n_fail++; $display("FAIL prio_id_mem: got %b want 011111", stall); end
      stallreq_from_mem = 1'b0;
      #1;
      n_checks++;
      if (stall !== 6'b000111) begin n_fail++; $display("FAIL prio_id: got %b want 000111", stall); end
      stallreq_from_id = 1'b0; stallreq_from_if = 1'b1;
      #1;
      n_checks++;
      if (stall !== 6'b000011) begin n_fail++; $display("FAIL prio_if: got %b want 000011", stall); end
      stallreq_from_mem = 1'b1; flush = 1'b1;
      #1;
      n_checks++;
      if (stall !== 6'b000000) begin n_fail++; $display("FAIL prio_flush: got %b want 000000", stall); end
      stallreq_from_if = 1'b0; stallreq_from_mem = 1'b0; flush = 1'b0;
   endtask

   task automatic test_done_mem_hold();
      tick();
      ex_aluop = EXE_DIVU_OP;
      tick();
      div_ready_i = 1'b1; div_result_i = 64'h1234_5678_9abc_def0;
      tick();
      div_ready_i = 1'b0; div_result_i = 64'h5555_5555_5555_5555; stallreq_from_mem = 1'b1;
      for (int k = 0; k < 3; k++) begin
         #1;
         n_checks++;
         if (dut.state_q !== MC_DIV_DONE || div_result_o !== 64'h1234_5678_9abc_def0 || stall !== 6'b011111) begin
            n_fail++; $display("FAIL mem_hold_%0d: state %0d res %h stall %b want %0d/123456789abcdef0/011111",
               k, dut.state_q, div_result_o, stall, MC_DIV_DONE);
         end
         tick();
      end
      stallreq_from_mem = 1'b0;
      #1;
      n_checks++;
      if (dut.state_q !== MC_DIV_DONE || stall !== 6'b000000 || div_result_valid_o !== 1'b1) begin
         n_fail++; $display("FAIL mem_release: state %0d stall %b valid %b want %0d/000000/1",
            dut.state_q, stall, div_result_valid_o, MC_DIV_DONE);
      end
      tick();
      ex_aluop = EXE_NOP_OP;
      #1;
      n_checks++;
      if (dut.state_q !== MC_IDLE) begin n_fail++; $display("FAIL mem_exit: got %0d want %0d", dut.state_q, MC_IDLE); end
   endtask

   task automatic test_timeout();
      tick();
      ex_aluop = EXE_DIV_OP;
      for (int k = 1; k <= 40; k++) tick();
      #1;
      n_checks++;
      if (div_timeout_o !== 1'b0 || dut.state_q !== MC_DIV_WAIT) begin
         n_fail++; $display("FAIL timeout_early: to %b state %0d want 0/%0d", div_timeout_o, dut.state_q, MC_DIV_WAIT);
      end
      tick();
      #1;
      n_checks++;
      if (div_timeout_o !== 1'b1 || stall !== 6'b001111) begin
         n_fail++; $display("FAIL timeout_set: to %b stall %b want 1/001111", div_timeout_o, stall);
      end
      tick();
      flush = 1'b1;
      tick();
      flush = 1'b0; ex_aluop = EXE_NOP_OP;
      tick(); tick();
      #1;
      n_checks++;
      if (div_timeout_o !== 1'b1 || dut.state_q !== MC_IDLE) begin
         n_fail++; $display("FAIL timeout_sticky: to %b state %0d want 1/%0d", div_timeout_o, dut.state_q, MC_IDLE);
      end
      tick();
      rst = 1'b1; ex_aluop = EXE_DIV_OP; stallreq_from_mem = 1'b1;
      #1;
      n_checks++;
      if (stall !== 6'b000000 || div_start_o !== 1'b0 || div_signed_o !== 1'b0) begin
         n_fail++; $display("FAIL rst_comb: stall %b start %b signed %b want 000000/0/0", stall, div_start_o, div_signed_o);
      end
      tick();
      #1;
      n_checks++;
      if (div_timeout_o !== 1'b0 || hilo_temp_o !== 64'h0 || div_result_o !== 64'h0 || dut.state_q !== MC_IDLE) begin
         n_fail++; $display("FAIL rst_clear: to %b hilo %h res %h state %0d want 0/0/0/%0d",
            div_timeout_o, hilo_temp_o, div_result_o, dut.state_q, MC_IDLE);
      end
      rst = 1'b0; ex_aluop = EXE_NOP_OP; stallreq_from_mem = 1'b0;
   endtask

   initial begin
      test_reset();
      test_madd();
      test_divu();
      test_flush();
      test_stall_prio();
      test_done_mem_hold();
      test_timeout();
      tick();
      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule
